// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the multi-word carry-select sequencer.
package csa_seq_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// 8-bit carry-select adder: 4-bit ripple low half, upper half precomputed for both carries.
module carry_select_adder (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, A[3:0]} + {1'b0, B[3:0]} + {4'b0000, Cin};
  assign hi0 = {1'b0, A[7:4]} + {1'b0, B[7:4]};
  assign hi1 = {1'b0, A[7:4]} + {1'b0, B[7:4]} + 5'd1;

  assign S    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign Cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/csa_multiword_seq.sv
// Wide adder built by stepping one 8-bit carry_select_adder across NUM_SLICES slices, LSB first.
// Optional subtract mode is enabled with the CSA_SEQ_SUB_EN macro.
//   state | meaning
//   IDLE  | cmd_ready high, waiting for an operand pair
//   RUN   | one slice per cycle, carry held between slices
//   DONE  | result presented until res_ready
module csa_multiword_seq
  import csa_seq_pkg::*;
#(
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] op_a,
  input  logic [SLICE_W*NUM_SLICES-1:0] op_b,
  input  logic                          cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic                          sub,
`endif
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] sum,
  output logic                          cout,
  output logic                          ovf
);

  localparam int IW = cnt_w(NUM_SLICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

  state_t state;
  logic [IW-1:0] idx;
  logic carry;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] opa;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] opb;
  logic [NUM_SLICES-1:0][SLICE_W-1:0] acc;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic c_sl;
  logic init_carry;

`ifdef CSA_SEQ_SUB_EN
  logic sub_r;
  // Subtraction is A + ~B + 1, so cin is ignored in that mode.
  assign b_sl       = opb[idx] ^ {SLICE_W{sub_r}};
  assign init_carry = sub | cin;
`else
  assign b_sl       = opb[idx];
  assign init_carry = cin;
`endif

  assign a_sl = opa[idx];
  assign sum  = acc;

  carry_select_adder u_csa (
    .A    (a_sl),
    .B    (b_sl),
    .Cin  (carry),
    .S    (s_sl),
    .Cout (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      cmd_ready <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
      sub_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            opa       <= op_a;
            opb       <= op_b;
            carry     <= init_carry;
            acc       <= '0;
            idx       <= '0;
            cmd_ready <= 1'b0;
            state     <= RUN;
`ifdef CSA_SEQ_SUB_EN
            sub_r     <= sub;
`endif
          end
        end
        RUN: begin
          acc[idx] <= s_sl;
          carry    <= c_sl;
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            cout      <= c_sl;
            ovf       <= (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) && (s_sl[SLICE_W-1] != a_sl[SLICE_W-1]);
            res_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_multiword_seq.sv
// Directed self-checking bench for csa_multiword_seq (default NUM_SLICES=4).
module tb_csa_multiword_seq;

  localparam int N = 4;
  localparam int W = 8 * N;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
`ifdef CSA_SEQ_SUB_EN
  logic         sub;
`endif

  int errors = 0;
  int checks = 0;

  csa_multiword_seq #(.NUM_SLICES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
`ifdef CSA_SEQ_SUB_EN
    .sub       (sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command: hold = cycles of res_ready=0 after res_valid; busy keeps cmd_valid high during RUN.
  task automatic do_cmd(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec, input logic eo,
                        input int hold, input bit busy);
    @(negedge clk);
    chk({tag, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    op_a      = a;
    op_b      = b;
    cin       = c;
    res_ready = (hold == 0);
    @(negedge clk);
    chk({tag, ".ready_low"}, cmd_ready, 0);
    chk({tag, ".sum_clr"}, sum, 0);
    if (!busy) cmd_valid = 1'b0;
    op_a = 32'hDEAD_BEEF;
    op_b = 32'hCAFE_F00D;
    cin  = ~c;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      chk({tag, ".lat"}, res_valid, (k == N));
      if (busy) chk({tag, ".busy_ready"}, cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, cout, ec);
    chk({tag, ".ovf"}, ovf, eo);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, res_valid, 1);
      chk({tag, ".hold_sum"}, sum, es);
      chk({tag, ".hold_cout"}, cout, ec);
      chk({tag, ".hold_ready"}, cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".valid_drop"}, res_valid, 0);
    chk({tag, ".ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    res_ready = 1'b1;
`ifdef CSA_SEQ_SUB_EN
    sub       = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.cmd_ready", cmd_ready, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.sum", sum, 0);
    chk("rst.cout", cout, 0);
    chk("rst.ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("rst.ready_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("rst.ready_after_edge", cmd_ready, 1);

    do_cmd("carry", 32'h0000_0096, 32'h0000_0079, 1'b0, 32'h0000_010F, 1'b0, 1'b0, 0, 0);
    do_cmd("chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0, 0);
    do_cmd("ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, 0);
    do_cmd("bp",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 6, 0);
    do_cmd("busy",  32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 32'h1010_1011, 1'b0, 1'b0, 0, 1);

    // Reset two slices into a run; the partial result must never surface.
    @(negedge clk);
    cmd_valid = 1'b1;
    op_a      = 32'h1234_5678;
    op_b      = 32'h1111_1111;
    cin       = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.partial", sum, 32'h0000_6789);
    rst_n = 1'b0;
    #1;
    chk("midrst.sum", sum, 0);
    chk("midrst.cout", cout, 0);
    chk("midrst.ovf", ovf, 0);
    chk("midrst.res_valid", res_valid, 0);
    chk("midrst.cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst.no_valid", res_valid, 0);
    end
    do_cmd("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0, 0);

`ifdef CSA_SEQ_SUB_EN
    sub = 1'b1;
    do_cmd("sub", 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 0);
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_multiword_seq.md
Name: csa_multiword_seq

Overview:
- Sequencer that performs wide (NUM_SLICES x 8-bit) additions by time-multiplexing one instance of the team's 8-bit carry_select_adder.
- Feeds one byte slice per cycle, LSB first, and registers the carry between slices.
- Sits between a requester (valid/ready command) and a consumer (valid/ready result).
- Trades latency for area in place of a full-width adder.

Parameters:
- NUM_SLICES, 4, number of 8-bit slices; total operand width W = 8*NUM_SLICES; legal range 2..16.
- SLICE_W, 8, slice width; fixed to the carry_select_adder width and not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  requester has an operand pair.
- cmd_ready  out  1  block can accept a command.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- cin  in  1  carry into slice 0.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- sum  out  W  result.
- cout  out  1  carry out of the top slice.
- ovf  out  1  signed overflow of the W-bit result.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0, all state clears immediately: FSM=IDLE, slice counter=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, res_valid=0, cmd_ready=0.
- cmd_ready goes to 1 on the first clk edge after rst_n deasserts.
- FSM states:
  - IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op_a, op_b and cin into the carry reg, clear sum, set idx=0, go to RUN.
  - RUN: cmd_ready=0. Drive adder with A=opa_reg[idx*8+:8], B=opb_reg[idx*8+:8], Cin=carry reg.
    - Each cycle, write S into sum[idx*8+:8], load Cout into the carry reg, and increment idx.
    - When idx==NUM_SLICES-1: also set cout=Cout, set ovf=(A[7]==B[7])&&(S[7]!=A[7]) for the top slice, and go to DONE.
  - DONE: res_valid=1. Hold sum, cout and ovf stable. When res_ready=1, go to IDLE with res_valid=0 on the next cycle.
- Latency: res_valid rises exactly NUM_SLICES cycles after the accepting edge (4 for the default).
- Minimum command period: NUM_SLICES+2 cycles with res_ready tied high.
- Commands are not accepted while in RUN or DONE (no overlap). cmd_valid asserted there is simply held off.
- sum is partially updated during RUN. Consumers sample it only when res_valid=1.
- cmd_valid with X operands in IDLE while cmd_valid=0 has no effect; operand regs update only on acceptance.
- Reset mid-RUN or mid-DONE aborts immediately. The result is discarded and never presented.
- The adder is purely combinational. Its output is registered inside this block; there is no combinational path from any input to any output except res_ready -> none (all outputs registered).

Optional Feature:
- Macro: CSA_SEQ_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), latched on acceptance.
  - When sub=1: B slices are bit-inverted before the adder, the initial carry reg is forced to 1 (cin ignored), and the result is A-B.
  - cout=1 means no borrow. ovf uses the inverted B MSB.
- Undefined: no sub port; addition only; logic identical to the base description.

Decomposition:
- Package csa_seq_pkg:
  - FSM state typedef (IDLE, RUN, DONE; 2-bit encoding).
  - SLICE_W constant (8).
  - Function computing the counter width, clog2(NUM_SLICES).
- Sub-module: reuse the existing carry_select_adder (ports A, B, Cin, S, Cout) as the single instantiated datapath. No new sub-module.

Test Plan:
- Slice-to-slice carry: op_a=0x00000096, op_b=0x00000079, cin=0, res_ready=1 -> after 4 cycles sum=0x0000010F, cout=0, ovf=0.
- Full carry chain: op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
- Signed overflow: op_a=0x7FFFFFFF, op_b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Backpressure: hold res_ready=0 for 6 cycles after res_valid -> res_valid, sum and cout stay stable, cmd_ready=0 throughout; release -> cmd_ready=1 the next cycle.
- Reset mid-RUN: assert rst_n=0 at idx=2 -> all outputs 0 immediately, no res_valid afterward. A following command 0x12345678+0x11111111 yields 0x23456789.
- (CSA_SEQ_SUB_EN) op_a=5, op_b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
